// File: rtl/dbf_scan_ctrl_pkg.sv
// Shared types, parameter defaults and elaboration-time fit checks for the DBF scan-line sequencer.
package dbf_scan_ctrl_pkg;

    localparam int unsigned DEF_ADDR_WD      = 10;
    localparam int unsigned DEF_LINE_WD      = 8;
    localparam int unsigned DEF_NUM_LINES    = 128;
    localparam int unsigned DEF_LUT_PER_LINE = 8;
    localparam int unsigned DEF_TX_CYCLES    = 16;
    localparam int unsigned DEF_RX_SAMPLES   = 2048;
    localparam int unsigned DEF_CNT_WD       = 12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_TX   = 3'd2,
        ST_RX   = 3'd3,
        ST_EOL  = 3'd4
    } scan_state_e;

    // Every line's LUT slice must land inside the channel LUT address space.
    function automatic bit addr_fits(input int unsigned lines, input int unsigned lpl,
                                     input int unsigned aw);
        return (longint'(lines) * longint'(lpl)) <= (longint'(1) << aw);
    endfunction

    // The phase counter is loaded with length-1, so the longest phase must fit.
    function automatic bit cnt_fits(input int unsigned tx, input int unsigned rx,
                                    input int unsigned cw);
        longint mx;
        mx = (tx > rx) ? longint'(tx) : longint'(rx);
        return mx <= ((longint'(1) << cw) - 1);
    endfunction

endpackage

// File: rtl/dbf_phase_cnt.sv
// Loadable down-counter with a terminal flag; times both the TX and the RX window.
module dbf_phase_cnt #(
    parameter int unsigned CNT_WD = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CNT_WD-1:0] load_val,
    input  logic              en,
    output logic              term_c
);

    logic [CNT_WD-1:0] cnt_q;
    logic [CNT_WD-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WD'(1);
        end
    end

    // rst_n is active-high on this block.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_c = (cnt_q == '0);

endmodule

// File: rtl/dbf_scan_ctrl.sv
// Per-scan-line sequencer: LUT slice load, TX window, RX/beamform window, end-of-line, per frame.
module dbf_scan_ctrl
    import dbf_scan_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WD      = DEF_ADDR_WD,
    parameter int unsigned LINE_WD      = DEF_LINE_WD,
    parameter int unsigned NUM_LINES    = DEF_NUM_LINES,
    parameter int unsigned LUT_PER_LINE = DEF_LUT_PER_LINE,
    parameter int unsigned TX_CYCLES    = DEF_TX_CYCLES,
    parameter int unsigned RX_SAMPLES   = DEF_RX_SAMPLES,
    parameter int unsigned CNT_WD       = DEF_CNT_WD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_go,
    input  logic               abort,
    input  logic               lut_data_valid,
    output logic               lut_req,
    output logic [ADDR_WD-1:0] dbf_lut_addr,
    output logic               dbf_lut_we,
    output logic               tx_en,
    output logic               start,
    output logic [LINE_WD-1:0] line_idx,
    output logic               line_done,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned K_WD = (LUT_PER_LINE > 1) ? $clog2(LUT_PER_LINE) : 1;

    if (!addr_fits(NUM_LINES, LUT_PER_LINE, ADDR_WD)) begin : g_addr_chk
        $error("dbf_scan_ctrl: NUM_LINES*LUT_PER_LINE exceeds the LUT address space");
    end
    if (!cnt_fits(TX_CYCLES, RX_SAMPLES, CNT_WD)) begin : g_cnt_chk
        $error("dbf_scan_ctrl: CNT_WD too narrow for TX_CYCLES/RX_SAMPLES");
    end

    scan_state_e        state_q, state_d;
    logic [LINE_WD-1:0] line_q, line_d;
    logic [K_WD-1:0]    k_q, k_d;
    logic [ADDR_WD-1:0] addr_q, addr_d;
    logic               we_q, we_d;
    logic               lut_req_q, lut_req_d;
    logic               tx_en_q, tx_en_d;
    logic               start_q, start_d;
    logic               line_done_q, line_done_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

    logic               cnt_load;
    logic [CNT_WD-1:0]  cnt_val;
    logic               cnt_en;
    logic               cnt_term_c;

    dbf_phase_cnt #(.CNT_WD(CNT_WD)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .term_c   (cnt_term_c)
    );

    // Outputs are the registered image of what the current state does this cycle.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        k_d          = k_q;
        addr_d       = '0;
        we_d         = 1'b0;
        tx_en_d      = 1'b0;
        start_d      = 1'b0;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_go) begin
                    state_d = ST_LOAD;
                    line_d  = '0;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                if (lut_data_valid) begin
                    we_d   = 1'b1;
                    addr_d = ADDR_WD'(line_q) * ADDR_WD'(LUT_PER_LINE) + ADDR_WD'(k_q);
                    if (k_q == K_WD'(LUT_PER_LINE - 1)) begin
                        state_d  = ST_TX;
                        k_d      = '0;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_WD'(TX_CYCLES - 1);
                    end else begin
                        k_d = k_q + K_WD'(1);
                    end
                end
            end
            ST_TX: begin
                tx_en_d = 1'b1;
                if (cnt_term_c) begin
                    state_d  = ST_RX;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_WD'(RX_SAMPLES - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_RX: begin
                start_d = 1'b1;
                if (cnt_term_c) begin
                    state_d = ST_EOL;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_EOL: begin
                line_done_d = 1'b1;
                if (line_q == LINE_WD'(NUM_LINES - 1)) begin
                    frame_done_d = 1'b1;
                    line_d       = '0;
                    state_d      = ST_IDLE;
                end else begin
                    line_d  = line_q + LINE_WD'(1);
                    k_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including the end-of-line pulses.
        if (abort) begin
            state_d      = ST_IDLE;
            line_d       = '0;
            k_d          = '0;
            addr_d       = '0;
            we_d         = 1'b0;
            tx_en_d      = 1'b0;
            start_d      = 1'b0;
            line_done_d  = 1'b0;
            frame_done_d = 1'b0;
            cnt_load     = 1'b1;
            cnt_val      = '0;
            cnt_en       = 1'b0;
        end

        lut_req_d = (state_d == ST_LOAD);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= ST_IDLE;
            line_q       <= '0;
            k_q          <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            lut_req_q    <= 1'b0;
            tx_en_q      <= 1'b0;
            start_q      <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            lut_req_q    <= lut_req_d;
            tx_en_q      <= tx_en_d;
            start_q      <= start_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign lut_req      = lut_req_q;
    assign dbf_lut_addr = addr_q;
    assign dbf_lut_we   = we_q;
    assign tx_en        = tx_en_q;
    assign start        = start_q;
    assign line_idx     = line_q;
    assign line_done    = line_done_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dbf_scan_ctrl.sv
// Scoreboard bench for dbf_scan_ctrl: a cycle-stamped frame model fills expectation queues, a monitor drains them.
module tb_dbf_scan_ctrl;

    localparam int unsigned ADDR_WD = 10;
    localparam int unsigned LINE_WD = 8;
    localparam int unsigned NL      = 3;
    localparam int unsigned LPL     = 4;
    localparam int unsigned TXC     = 2;
    localparam int unsigned RXC     = 5;
    localparam int unsigned CNT_WD  = 12;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic               clk;
    logic               rst_n;
    logic               frame_go;
    logic               abort;
    logic               lut_data_valid;
    logic               lut_req;
    logic [ADDR_WD-1:0] dbf_lut_addr;
    logic               dbf_lut_we;
    logic               tx_en;
    logic               start;
    logic [LINE_WD-1:0] line_idx;
    logic               line_done;
    logic               frame_done;
    logic               busy;

    dbf_scan_ctrl #(
        .ADDR_WD(ADDR_WD), .LINE_WD(LINE_WD), .NUM_LINES(NL), .LUT_PER_LINE(LPL),
        .TX_CYCLES(TXC), .RX_SAMPLES(RXC), .CNT_WD(CNT_WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .abort(abort),
        .lut_data_valid(lut_data_valid), .lut_req(lut_req), .dbf_lut_addr(dbf_lut_addr),
        .dbf_lut_we(dbf_lut_we), .tx_en(tx_en), .start(start), .line_idx(line_idx),
        .line_done(line_done), .frame_done(frame_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int line; } wr_t;
    typedef struct { int cyc; bit last; } ld_t;
    typedef struct { int lo; int cut; } win_t;
    typedef struct { int cyc; int mode; } md_t;

    wr_t  q_wr[$];
    ld_t  q_ld[$];
    win_t q_win[$];
    md_t  q_md[$];

    int checks = 0;
    int errors = 0;
    int cur_mode = M_IDLE;

    // Frame model state: what the controller should be doing, in frame/line/word terms.
    bit m_run = 0;
    bit m_end_pending = 0;
    int m_line, m_k, m_load_from, m_end;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Drop every expectation at or after cycle c.
    task automatic trim(input int c);
        while (q_wr.size() > 0 && q_wr[$].cyc >= c) void'(q_wr.pop_back());
        while (q_ld.size() > 0 && q_ld[$].cyc >= c) void'(q_ld.pop_back());
        while (q_md.size() > 0 && q_md[$].cyc >= c) void'(q_md.pop_back());
        foreach (q_win[i]) if (q_win[i].cut > c) q_win[i].cut = c;
    endtask

    task automatic model_step(input int c, input bit go, input bit ab, input bit v);
        md_t md;
        if (ab) begin
            trim(c + 1);
            md.cyc = c + 1; md.mode = M_IDLE; q_md.push_back(md);
            m_run = 0; m_end_pending = 0;
            return;
        end
        if (m_run && m_end_pending && c >= m_end) begin
            m_run = 0; m_end_pending = 0;
        end
        if (!m_run && go) begin
            m_run = 1; m_line = 0; m_k = 0; m_load_from = c + 1;
            md.cyc = c + 1; md.mode = M_RUN; q_md.push_back(md);
        end
        if (m_run && !m_end_pending && c >= m_load_from && v) begin
            wr_t w; ld_t l; win_t wn; int done;
            w.cyc = c + 1; w.addr = m_line * LPL + m_k; w.line = m_line;
            q_wr.push_back(w);
            m_k++;
            if (m_k == LPL) begin
                done = c + TXC + RXC + 2;
                wn.lo = c + 2; wn.cut = 32'h7fff_ffff; q_win.push_back(wn);
                l.cyc = done; l.last = (m_line == NL - 1); q_ld.push_back(l);
                if (l.last) begin
                    m_end = done; m_end_pending = 1;
                    md.cyc = done;     md.mode = M_DONE; q_md.push_back(md);
                    md.cyc = done + 1; md.mode = M_IDLE; q_md.push_back(md);
                end else begin
                    m_line++; m_k = 0; m_load_from = done;
                end
            end
        end
    endtask

    task automatic model_reset(input int c);
        md_t md;
        trim(c);
        md.cyc = c; md.mode = M_IDLE; q_md.push_back(md);
        m_run = 0; m_end_pending = 0;
    endtask

    task automatic drive(input bit go, input bit ab, input bit v);
        @(posedge clk); #1;
        frame_go = go; abort = ab; lut_data_valid = v;
        model_step(cyc, go, ab, v);
    endtask

    // Monitor: compare DUT outputs against the expectations stamped for this cycle.
    always @(negedge clk) begin
        int c;
        bit exp_we, exp_ld, exp_tx, exp_st;
        c = cyc;
        while (q_md.size() > 0 && q_md[0].cyc <= c) begin
            cur_mode = q_md[0].mode;
            if (cur_mode == M_RUN && q_md[0].cyc == c) chk("lut_req_after_go", int'(lut_req), 1);
            void'(q_md.pop_front());
        end
        if (cur_mode == M_IDLE) begin
            chk("idle_outputs", int'({lut_req, dbf_lut_we, tx_en, start, line_done, frame_done, busy}), 0);
            chk("idle_addr_line", int'(dbf_lut_addr) + int'(line_idx), 0);
        end else if (cur_mode == M_RUN) begin
            chk("busy_run", int'(busy), 1);
        end
        while (q_wr.size() > 0 && q_wr[0].cyc < c) void'(q_wr.pop_front());
        exp_we = (q_wr.size() > 0 && q_wr[0].cyc == c);
        chk("lut_we", int'(dbf_lut_we), int'(exp_we));
        if (exp_we) begin
            chk("lut_addr", int'(dbf_lut_addr), q_wr[0].addr);
            chk("line_idx_wr", int'(line_idx), q_wr[0].line);
            void'(q_wr.pop_front());
        end
        while (q_ld.size() > 0 && q_ld[0].cyc < c) void'(q_ld.pop_front());
        exp_ld = (q_ld.size() > 0 && q_ld[0].cyc == c);
        chk("line_done", int'(line_done), int'(exp_ld));
        if (exp_ld) begin
            chk("frame_done", int'(frame_done), int'(q_ld[0].last));
            void'(q_ld.pop_front());
        end else begin
            chk("frame_done_quiet", int'(frame_done), 0);
        end
        while (q_win.size() > 0 && q_win[0].lo + int'(TXC + RXC) - 1 < c) void'(q_win.pop_front());
        exp_tx = 0; exp_st = 0;
        foreach (q_win[i]) begin
            if (c < q_win[i].cut) begin
                if (c >= q_win[i].lo && c < q_win[i].lo + int'(TXC)) exp_tx = 1;
                if (c >= q_win[i].lo + int'(TXC) && c < q_win[i].lo + int'(TXC + RXC)) exp_st = 1;
            end
        end
        chk("tx_en", int'(tx_en), int'(exp_tx));
        chk("start", int'(start), int'(exp_st));
    end

    initial begin
        int g;
        int dones[$];
        int exp_off[3];
        int fdo, txr;
        bit found;
        exp_off[0] = 13; exp_off[1] = 25; exp_off[2] = 37;
        rst_n = 1'b1; frame_go = 1'b0; abort = 1'b0; lut_data_valid = 1'b0;

        // Reset then idle
        repeat (5) drive(0, 0, 0);
        rst_n = 1'b0;
        repeat (10) drive(0, 0, 0);
        chk("busy_after_reset", int'(busy), 0);

        // Nominal frame, valid tied high
        drive(1, 0, 1); g = cyc;
        for (int i = 1; i <= 37; i++) begin
            drive(0, 0, 1);
            if (line_done) dones.push_back(cyc - g);
        end
        chk("frame_done_at_37", int'(frame_done), 1);
        chk("line_done_count", dones.size(), 3);
        for (int i = 0; i < 3; i++) if (i < dones.size()) chk("line_done_offset", dones[i], exp_off[i]);

        // Back-to-back frame, with a frame_go pulsed during TX
        drive(1, 0, 1); g = cyc; fdo = -1;
        for (int i = 1; i <= 45; i++) begin
            drive(i == 6, 0, 1);
            if (frame_done && fdo < 0) fdo = cyc - g;
        end
        chk("frame2_length", fdo, 37);

        // LUT stall on words 2 and 3, then abort in RX of line 1
        drive(1, 0, 1); g = cyc; txr = -1; found = 0;
        for (int i = 1; i <= 80 && !found; i++) begin
            drive(0, 0, !((i >= 2 && i <= 4) || (i >= 6 && i <= 8)));
            if (tx_en && txr < 0) txr = cyc - g;
            found = start && (line_idx == LINE_WD'(1));
        end
        chk("tx_rise_with_stall", txr, 12);
        chk("reached_rx_line1", int'(found), 1);
        drive(0, 1, 1);
        drive(0, 0, 0);
        chk("start_after_abort", int'(start), 0);
        chk("busy_after_abort", int'(busy), 0);
        repeat (3) drive(0, 0, 0);
        drive(1, 0, 0); found = 0;
        for (int i = 0; i < 200 && !frame_done; i++) begin
            drive(0, 0, $urandom_range(0, 3) != 0);
            if (dbf_lut_we && !found) begin
                found = 1;
                chk("restart_addr", int'(dbf_lut_addr), 0);
                chk("restart_line", int'(line_idx), 0);
            end
        end
        chk("restart_frame_done", int'(frame_done), 1);
        repeat (2) drive(0, 0, 0);

        // Async reset mid-LOAD, off the clock edge
        drive(1, 0, 0);
        drive(0, 0, 1);
        drive(0, 0, 1);
        @(posedge clk); #3;
        rst_n = 1'b1; frame_go = 1'b0; abort = 1'b0; lut_data_valid = 1'b0;
        model_reset(cyc);
        #1;
        chk("we_async_reset", int'(dbf_lut_we), 0);
        chk("lut_req_async_reset", int'(lut_req), 0);
        chk("busy_async_reset", int'(busy), 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst_n = 1'b0;
        repeat (3) drive(0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7);
        end

        drive(0, 1, 0);
        repeat (3) drive(0, 0, 0);
        chk("wr_queue_drained", q_wr.size(), 0);
        chk("ld_queue_drained", q_ld.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbf_scan_ctrl.md
# dbf_scan_ctrl

Per-scan-line sequencer for the DBF channel array. For each line of a frame it loads that line's delay-LUT slice into every channel (broadcast `dbf_lut_addr`/`dbf_lut_we`), holds `tx_en` for the transmit window, then asserts `start` for the receive/beamform window. It then advances to the next line and repeats until the frame ends. Sits between the host/frame logic and the `dbf_chNN` instances; all channels share its outputs.

## Interface
- `ADDR_WD`, 10: LUT address width; must satisfy NUM_LINES*LUT_PER_LINE <= 2^ADDR_WD.
- `LINE_WD`, 8: line index width.
- `NUM_LINES`, 128: lines per frame (>= 1).
- `LUT_PER_LINE`, 8: LUT entries written per line (>= 1).
- `TX_CYCLES`, 16: `tx_en` high-time per line (>= 1).
- `RX_SAMPLES`, 2048: `start` high-time per line (>= 1).
- `CNT_WD`, 12: phase counter width; must hold max(TX_CYCLES, RX_SAMPLES).
- `clk`  in  1  system clock (40 MHz).
- `rst_n`  in  1  reset; asynchronous, active-high (1 = reset) despite the name.
- `frame_go`  in  1  one-cycle request to run a frame; honoured only in IDLE.
- `abort`  in  1  level; forces IDLE.
- `lut_data_valid`  in  1  host has the next LUT word on the shared LUT data bus.
- `lut_req`  out  1  controller is in LOAD and wants LUT words.
- `dbf_lut_addr`  out  ADDR_WD  LUT write address to all channels.
- `dbf_lut_we`  out  1  LUT write strobe to all channels.
- `tx_en`  out  1  transmit window.
- `start`  out  1  beamform window.
- `line_idx`  out  LINE_WD  current line.
- `line_done`  out  1  one-cycle pulse at end of each line.
- `frame_done`  out  1  one-cycle pulse at end of last line.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOAD, TX, RX, EOL.
- IDLE: all outputs 0. `frame_go`=1 -> LOAD, `line_idx`=0, `k`=0.
- LOAD: `lut_req`=1. Each cycle with `lut_data_valid`=1 -> write `dbf_lut_addr` = `line_idx`*LUT_PER_LINE + `k`, `k`++. Cycles with valid=0 stall with no write. The write of k = LUT_PER_LINE-1 -> TX.
- TX: `tx_en`=1 for exactly TX_CYCLES cycles -> RX.
- RX: `start`=1 for exactly RX_SAMPLES cycles -> EOL.
- EOL: one cycle with `line_done`=1.
  - If `line_idx` = NUM_LINES-1: also `frame_done`=1, `line_idx` -> 0, next IDLE.
  - Else: `line_idx`++, `k`=0, next LOAD.
- `abort`=1, any state -> IDLE next cycle. Counters and `line_idx` clear, no done pulses. Abort wins over `frame_go` and over the EOL pulses in the same cycle.
- `frame_go` while `busy` is ignored (not queued).
- `tx_en` and `start` are never high together; `dbf_lut_we` is never high outside LOAD.

## Timing
- All outputs registered; reset value 0 for every output.
- Reset asserted mid-frame: outputs 0 immediately (async), IDLE on release.
- `frame_go` at cycle n -> `lut_req`=1 at n+1.
- `lut_data_valid` at cycle m -> `dbf_lut_we`/`dbf_lut_addr` at m+1. The host drives the data bus so the word is stable at m+1.
- Last LUT write at cycle w -> `tx_en` rises at w+1.
- `tx_en` falls and `start` rises in the same edge; `start` falls at the `line_done` edge.
- Line period with no stalls: LUT_PER_LINE + TX_CYCLES + RX_SAMPLES + 1 cycles.
- `frame_go` accepted on the cycle after `frame_done` (IDLE).

## Structure
- Shared package/header: state encoding constants, parameter defaults, and the address-fit and counter-fit checks (elaboration-time).
- Single module. One sub-module is natural: `dbf_phase_cnt`, a loadable down-counter with a terminal flag, instanced once and reused for TX and RX lengths.

## Test plan
- Reset then idle: hold `rst_n`=1 for 5 cycles, release -> all outputs 0, `busy`=0 for 10 cycles with no `frame_go`.
- Nominal frame with NUM_LINES=3, LUT_PER_LINE=4, TX_CYCLES=2, RX_SAMPLES=5, valid tied high:
  - Addresses 0-3, 4-7, 8-11, each followed by 2 `tx_en` cycles and 5 `start` cycles.
  - `line_done` at cycles 13, 25, 37 after `frame_go`; `frame_done` with the third.
- LUT stall: `lut_data_valid` low on the 2nd and 3rd words for 3 cycles each -> addresses still contiguous, no `dbf_lut_we` during gaps, TX delayed by 6 cycles.
- Abort in RX of line 1 -> `start`=0 and `busy`=0 next cycle, no `line_done`. The next `frame_go` restarts at address 0, `line_idx`=0.
- `frame_go` pulsed during TX -> ignored; frame length unchanged. `frame_go` the cycle after `frame_done` -> new frame starts.
- Async reset asserted mid-LOAD (not clock-aligned) -> `dbf_lut_we`, `lut_req`, `busy` drop before the next edge.
